// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the seven-segment display path.
// Segment patterns are active-low in {a,b,c,d,e,f,g,dp} order.
package seven_seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_ZERO  = 8'h03;
  localparam logic [7:0] SEG_A     = 8'h11;
  localparam logic [7:0] SEG_U     = 8'h83;
  localparam logic [7:0] SEG_L     = 8'hE3;

  localparam int SEG_BIT_A  = 7;
  localparam int SEG_BIT_B  = 6;
  localparam int SEG_BIT_C  = 5;
  localparam int SEG_BIT_D  = 4;
  localparam int SEG_BIT_E  = 3;
  localparam int SEG_BIT_F  = 2;
  localparam int SEG_BIT_G  = 1;
  localparam int SEG_BIT_DP = 0;

  typedef enum logic {
    ST_DEAD  = 1'b0,
    ST_DRIVE = 1'b1
  } slot_state_t;

  function automatic int min_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seven_seg_scan_timer.sv
// Slot/digit counters for the display scan, plus the per-slot DEAD/DRIVE FSM.
// Emits the current digit, the dead-time flag and the slot/frame wrap strobes.
module seven_seg_scan_timer
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 500,
  parameter int DIG_W       = min_width(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [DIG_W-1:0] digit,
  output logic             in_dead,
  output logic             slot_wrap,
  output logic             frame_boundary
);

  localparam int CNT_W = min_width(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_END = CNT_W'(DEAD_CYCLES);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);
  localparam slot_state_t SLOT_START = (DEAD_CYCLES > 0) ? ST_DEAD : ST_DRIVE;

  logic [CNT_W-1:0] cnt, cnt_next;
  logic [DIG_W-1:0] digit_next;
  slot_state_t      state, state_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      digit <= '0;
      state <= SLOT_START;
    end else begin
      cnt   <= cnt_next;
      digit <= digit_next;
      state <= state_next;
    end
  end

  // Each slot opens in DEAD (unless there is no dead time) and leaves it once
  // the counter reaches the end of the dead window.
  always_comb begin
    slot_wrap      = (cnt == CNT_LAST);
    frame_boundary = slot_wrap && (digit == DIG_LAST);
    cnt_next       = slot_wrap ? '0 : cnt + 1'b1;
    digit_next     = digit;
    state_next     = state;
    if (slot_wrap) begin
      digit_next = (digit == DIG_LAST) ? '0 : digit + 1'b1;
    end
    case (state)
      ST_DEAD:  if (cnt_next == DEAD_END) state_next = ST_DRIVE;
      ST_DRIVE: if (slot_wrap) state_next = SLOT_START;
      default:  state_next = SLOT_START;
    endcase
    in_dead = (state == ST_DEAD);
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed seven-segment driver: double-buffered patterns swapped only
// at frame boundaries, dead-time between digits, registered active-low outputs.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*NUM_DIGITS-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    load,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int DIG_W = min_width(NUM_DIGITS);

  logic [DIG_W-1:0]               digit;
  logic                           in_dead;
  logic                           slot_wrap;
  logic                           frame_boundary;
  logic [NUM_DIGITS-1:0][7:0]     active;
  logic [NUM_DIGITS-1:0][7:0]     pending;
  logic                           pending_valid;
  logic [7:0]                     seg_next;
  logic [NUM_DIGITS-1:0]          an_next;
  logic                           frame_done_next;

  seven_seg_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYCLES (DEAD_CYCLES),
    .DIG_W       (DIG_W)
  ) u_timer (
    .clk            (clk),
    .rst            (rst),
    .digit          (digit),
    .in_dead        (in_dead),
    .slot_wrap      (slot_wrap),
    .frame_boundary (frame_boundary)
  );

  // A load landing on the boundary itself bypasses the pending buffer and
  // discards whatever was waiting there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active        <= {NUM_DIGITS{SEG_BLANK}};
      pending       <= {NUM_DIGITS{SEG_BLANK}};
      pending_valid <= 1'b0;
    end else if (frame_boundary) begin
      if (load) begin
        active <= seg_in;
      end else if (pending_valid) begin
        active <= pending;
      end
      pending_valid <= 1'b0;
    end else if (load) begin
      pending       <= seg_in;
      pending_valid <= 1'b1;
    end
  end

  always_comb begin
    seg_next        = SEG_BLANK;
    an_next         = '1;
    frame_done_next = slot_wrap && frame_boundary;
    if (!in_dead) begin
      an_next[digit] = 1'b0;
      if (!blank_mask[digit]) begin
        seg_next = active[digit];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_out    <= SEG_BLANK;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      seg_out    <= seg_next;
      an         <= an_next;
      frame_done <= frame_done_next;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: a cycle-indexed reference model pushes
// expected outputs at each clock edge and a monitor pops and compares them.
module tb_seven_seg_scan;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int DC = 2;

  typedef struct {
    logic [7:0]    seg;
    logic [ND-1:0] an;
    logic          fd;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [8*ND-1:0] seg_in;
  logic [ND-1:0]   blank_mask;
  logic            load;
  logic [7:0]      seg_out;
  logic [ND-1:0]   an;
  logic            frame_done;

  exp_t       exp_q[$];
  logic [7:0] m_active[ND];
  logic [7:0] m_pending[ND];
  bit         m_pv;
  int         k;
  int         n_checks;
  int         n_fails;

  seven_seg_scan #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .DEAD_CYCLES (DC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .blank_mask (blank_mask),
    .load       (load),
    .seg_out    (seg_out),
    .an         (an),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: k counts cycles since reset release; slot position and
  // digit follow directly from k, buffers follow the load/swap rules.
  always @(posedge clk) begin : model
    exp_t e;
    int   c;
    int   d;
    bit   boundary;
    if (rst) begin
      k    = 0;
      m_pv = 0;
      for (int i = 0; i < ND; i++) begin
        m_active[i]  = 8'hFF;
        m_pending[i] = 8'hFF;
      end
      e.seg = 8'hFF;
      e.an  = '1;
      e.fd  = 1'b0;
    end else begin
      c        = k % RD;
      d        = (k / RD) % ND;
      boundary = (c == RD - 1) && (d == ND - 1);
      e.seg    = 8'hFF;
      e.an     = '1;
      e.fd     = boundary;
      if (c >= DC) begin
        e.an[d] = 1'b0;
        if (!blank_mask[d]) e.seg = m_active[d];
      end
      if (boundary) begin
        for (int i = 0; i < ND; i++) begin
          if (load)      m_active[i] = seg_in[8*i +: 8];
          else if (m_pv) m_active[i] = m_pending[i];
        end
        m_pv = 0;
      end else if (load) begin
        for (int i = 0; i < ND; i++) m_pending[i] = seg_in[8*i +: 8];
        m_pv = 1;
      end
      k++;
    end
    exp_q.push_back(e);
  end

  task automatic check_output(input string name, input logic [7:0] seg_exp,
                              input logic [ND-1:0] an_exp, input logic fd_exp);
    n_checks += 3;
    if (seg_out !== seg_exp) begin
      n_fails++;
      $display("[TB] FAIL %s seg_out @%0t: got %h expected %h", name, $time, seg_out, seg_exp);
    end
    if (an !== an_exp) begin
      n_fails++;
      $display("[TB] FAIL %s an @%0t: got %b expected %b", name, $time, an, an_exp);
    end
    if (frame_done !== fd_exp) begin
      n_fails++;
      $display("[TB] FAIL %s frame_done @%0t: got %b expected %b", name, $time, frame_done, fd_exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_output("scan", e.seg, e.an, e.fd);
    end
  end

  // Called at a falling edge; holds the given inputs for one full cycle.
  task automatic apply_stimulus(input logic ld, input logic [8*ND-1:0] data,
                                input logic [ND-1:0] mask);
    load       = ld;
    seg_in     = data;
    blank_mask = mask;
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, seg_in, blank_mask);
  endtask

  task automatic wait_until(input int c, input int d);
    int tries;
    tries = 0;
    while (!(((k % RD) == c) && (((k / RD) % ND) == d))) begin
      if (tries > 4 * RD * ND) begin
        n_checks++;
        n_fails++;
        $display("[TB] FAIL wait_until cnt=%0d digit=%0d: timed out, k=%0d", c, d, k);
        return;
      end
      @(negedge clk);
      tries++;
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    n_checks   = 0;
    n_fails    = 0;
    rst        = 1'b1;
    load       = 1'b0;
    seg_in     = '0;
    blank_mask = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset", 8'hFF, 4'b1111, 1'b0);
    rst = 1'b0;

    $display("[TB] basic scan");
    wait_until(3, 1);
    apply_stimulus(1'b1, {8'hE3, 8'h83, 8'h11, 8'h03}, 4'b0000);
    wait_until(0, 0);
    idle_cycles(RD * ND + 4);

    $display("[TB] tear-free update");
    wait_until(3, 1);
    apply_stimulus(1'b1, {$urandom, $urandom, $urandom, $urandom}, 4'b0000);
    idle_cycles(RD * ND + RD);

    $display("[TB] boundary collision");
    wait_until(2, 0);
    apply_stimulus(1'b1, 32'h1234_5678, 4'b0000);
    wait_until(RD - 1, ND - 1);
    apply_stimulus(1'b1, 32'h9ABC_DEF0, 4'b0000);
    idle_cycles(2 * RD * ND);

    $display("[TB] blanking");
    wait_until(0, 0);
    apply_stimulus(1'b0, seg_in, 4'b0100);
    idle_cycles(RD * ND - 1);
    apply_stimulus(1'b0, seg_in, 4'b0000);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      apply_stimulus($urandom_range(0, 7) == 0, {$urandom, $urandom, $urandom, $urandom},
                     ($urandom_range(0, 3) == 0) ? ND'($urandom) : ND'(0));
    end
    apply_stimulus(1'b0, seg_in, 4'b0000);

    $display("[TB] async reset mid-drive");
    wait_until(4, 3);
    #2 rst = 1'b1;
    #1 check_output("async_rst", 8'hFF, 4'b1111, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(2 * RD * ND);
    wait_until(5, 2);
    apply_stimulus(1'b1, {8'h03, 8'h11, 8'h83, 8'hE3}, 4'b0000);
    idle_cycles(2 * RD * ND);

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
